// File: rtl/mem_block_mover.sv
// mem_block_mover: copies `len` words from `src_adrs` to `dst_adrs` through a
// single-port synchronous memory, one read-then-write per word, ascending,
// with address arithmetic wrapping modulo 2^AW.
// Optional build macro MOVER_CHECKSUM_EN adds a `cksum` output that sums
// every written word modulo 2^DW.
module mem_block_mover #(
    parameter int unsigned AW     = 10,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] src_adrs,
    input  logic [AW-1:0] dst_adrs,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          mem_wea,
    output logic [AW-1:0] mem_adrs,
    output logic [DW-1:0] mem_datIn,
`ifdef MOVER_CHECKSUM_EN
    output logic [DW-1:0] cksum,
`endif
    input  logic [DW-1:0] mem_datOut
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_block_mover: RD_LAT must be in 1..4");
    end

    localparam logic [2:0] WaitInit = 3'(RD_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StWr,
        StDone
    } state_e;

    state_e        state_q;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] idx_q;
    logic [2:0]    wait_q;
    logic [DW-1:0] dat_q;
    logic          busy_q;
    logic          done_q;
    logic          wea_q;
    logic [AW-1:0] adrs_q;
`ifdef MOVER_CHECKSUM_EN
    logic [DW-1:0] cksum_q;
`endif

    // Sequencer: all state, pointers and outputs update here so every output is a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wea_q   <= 1'b0;
            adrs_q  <= '0;
`ifdef MOVER_CHECKSUM_EN
            cksum_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    wea_q  <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        src_q  <= src_adrs;
                        dst_q  <= dst_adrs;
                        len_q  <= len;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
`ifdef MOVER_CHECKSUM_EN
                        cksum_q <= '0;
`endif
                        if (len == '0) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StRd;
                            adrs_q  <= src_adrs;
                        end
                    end
                end
                StRd: begin
                    state_q <= StWait;
                    wait_q  <= WaitInit;
                end
                StWait: begin
                    // Address is held; the last wait edge sees valid read data.
                    if (wait_q == 3'd1) begin
                        dat_q   <= mem_datOut;
                        wea_q   <= 1'b1;
                        adrs_q  <= dst_q + idx_q;
                        state_q <= StWr;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                StWr: begin
                    wea_q <= 1'b0;
                    idx_q <= idx_q + AW'(1);
`ifdef MOVER_CHECKSUM_EN
                    cksum_q <= cksum_q + dat_q;
`endif
                    if (idx_q + AW'(1) == len_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StRd;
                        adrs_q  <= src_q + idx_q + AW'(1);
                    end
                end
                StDone: begin
                    // An empty copy enters here with done low: one busy cycle, then the pulse.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_wea   = wea_q;
    assign mem_adrs  = adrs_q;
    assign mem_datIn = dat_q;
`ifdef MOVER_CHECKSUM_EN
    assign cksum     = cksum_q;
`endif

endmodule
